// File: rtl/id_stage_pkg.sv
// Shared decode-stage types: opcodes, control encodings, the decode->execute bus and forwarding
// buses.
package id_stage_pkg;

  localparam int unsigned DS_ES_BUS_W = 153;
  localparam logic [31:0] EcallInst   = 32'h0000_0073;

  typedef enum logic [6:0] {
    OpLoad    = 7'h03,
    OpMiscMem = 7'h0f,
    OpImm     = 7'h13,
    OpAuipc   = 7'h17,
    OpStore   = 7'h23,
    OpReg     = 7'h33,
    OpLui     = 7'h37,
    OpBranch  = 7'h63,
    OpJalr    = 7'h67,
    OpJal     = 7'h6f,
    OpSystem  = 7'h73
  } opcode_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {BrNone, BrEq, BrNe, BrLt, BrGe, BrLtu, BrGeu} br_type_e;
  typedef enum logic [1:0] {Src1Rs1, Src1Pc, Src1Zero} src1_sel_e;
  typedef enum logic {Src2Rs2, Src2Imm} src2_sel_e;

  typedef struct packed {
    logic        illegal;
    logic        ecall;
    logic        is_jalr;
    logic        is_jal;
    br_type_e    br_type;
    logic [2:0]  mem_size;
    logic        mem_wen;
    logic        mem_ren;
    src2_sel_e   src2_sel;
    src1_sel_e   src1_sel;
    alu_op_e     alu_op;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [31:0] rs2_val;
    logic [31:0] rs1_val;
    logic [31:0] imm;
    logic [31:0] pc;
  } id_exe_bus_t;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] value;
  } es_fwd_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] value;
  } ms_fwd_t;

  // A load still in EXE has no value yet, so it never forwards; load_use covers that case.
  function automatic logic [31:0] pick_operand(input logic [4:0] rs, input es_fwd_t es,
                                               input ms_fwd_t ms, input logic [31:0] rf_val);
    if (rs == 5'd0) return 32'd0;
    if (es.valid && !es.is_load && es.rd == rs) return es.value;
    if (ms.valid && ms.rd == rs) return ms.value;
    return rf_val;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch->decode and decode->execute handshake signals.
interface id_stage_if;
  import id_stage_pkg::*;

  logic        fs_to_ds_valid;
  logic [63:0] if_id_bus;
  logic        ds_allowin;
  logic        es_allowin;
  logic        ds_to_es_valid;
  id_exe_bus_t id_exe_bus;

  modport master (
    output fs_to_ds_valid, if_id_bus, es_allowin,
    input  ds_allowin, ds_to_es_valid, id_exe_bus
  );

  modport slave (
    input  fs_to_ds_valid, if_id_bus, es_allowin,
    output ds_allowin, ds_to_es_valid, id_exe_bus
  );
endinterface

// File: rtl/id_stage_regfile_2r1w.sv
// 32x32 register file, two async read ports, one write port, x0 tied to zero, write-through.
module regfile_2r1w (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: latches fetch output, decodes, reads operands with forwarding, and
// stalls on load-use hazards.
module id_stage import id_stage_pkg::*; #(
  parameter logic [31:0] RESET_INST = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   pipe,
  output logic        ds_stall_flag,
  output logic        ecall_flag,
  input  logic        exe_flush,
  input  es_fwd_t     es_fwd_bus,
  input  ms_fwd_t     ms_fwd_bus,
  input  logic        ws_rf_we,
  input  logic [4:0]  ws_rf_waddr,
  input  logic [31:0] ws_rf_wdata
);

  logic        ds_valid_q;
  logic [31:0] inst_q, pc_q;
  logic        ds_ready_go, load_use, use_rs1, use_rs2, wr, illegal;
  logic [4:0]  rs1, rs2, rd_idx;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  opcode_e     opcode;
  id_exe_bus_t ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_valid_q <= 1'b0;
      inst_q     <= RESET_INST;
      pc_q       <= '0;
    end else if (exe_flush) begin
      ds_valid_q <= 1'b0;
    end else if (pipe.ds_allowin) begin
      ds_valid_q <= pipe.fs_to_ds_valid;
      if (pipe.fs_to_ds_valid) {inst_q, pc_q} <= pipe.if_id_bus;
    end
  end

  assign opcode = opcode_e'(inst_q[6:0]);
  assign rd_idx = inst_q[11:7];
  assign f3     = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign f7     = inst_q[31:25];

  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'd0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  regfile_2r1w u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (ws_rf_we),
    .waddr  (ws_rf_waddr),
    .wdata  (ws_rf_wdata),
    .raddr1 (rs1),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2),
    .rdata2 (rf_rdata2)
  );

  assign rs1_val = pick_operand(rs1, es_fwd_bus, ms_fwd_bus, rf_rdata1);
  assign rs2_val = pick_operand(rs2, es_fwd_bus, ms_fwd_bus, rf_rdata2);

  // Hazard sources are judged by instruction format, independent of legality.
  assign use_rs1 = !(opcode inside {OpLui, OpAuipc, OpJal});
  assign use_rs2 = opcode inside {OpReg, OpStore, OpBranch};

  assign load_use = ds_valid_q && es_fwd_bus.valid && es_fwd_bus.is_load &&
                    es_fwd_bus.rd != 5'd0 &&
                    ((use_rs1 && es_fwd_bus.rd == rs1) || (use_rs2 && es_fwd_bus.rd == rs2));

  assign ds_ready_go         = !load_use;
  assign ds_stall_flag       = load_use && ds_valid_q;
  assign pipe.ds_allowin     = !ds_valid_q || (ds_ready_go && pipe.es_allowin);
  assign pipe.ds_to_es_valid = ds_valid_q && ds_ready_go && !exe_flush;
  assign ecall_flag          = ds_valid_q && ctrl.ecall && ds_ready_go && pipe.es_allowin &&
                               !exe_flush;
  assign pipe.id_exe_bus     = ctrl;

  always_comb begin
    ctrl    = '0;
    wr      = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OpLui:   begin wr = 1'b1; ctrl.src1_sel = Src1Zero; ctrl.src2_sel = Src2Imm;
                     ctrl.imm = imm_u; end
      OpAuipc: begin wr = 1'b1; ctrl.src1_sel = Src1Pc; ctrl.src2_sel = Src2Imm;
                     ctrl.imm = imm_u; end
      OpJal:   begin wr = 1'b1; ctrl.is_jal = 1'b1; ctrl.src1_sel = Src1Pc;
                     ctrl.src2_sel = Src2Imm; ctrl.imm = imm_j; end
      OpJalr:  begin
        wr = 1'b1; ctrl.is_jalr = 1'b1; ctrl.src2_sel = Src2Imm; ctrl.imm = imm_i;
        illegal = (f3 != 3'd0);
      end
      OpBranch: begin
        ctrl.imm = imm_b;
        case (f3)
          3'd0: ctrl.br_type = BrEq;
          3'd1: ctrl.br_type = BrNe;
          3'd4: ctrl.br_type = BrLt;
          3'd5: ctrl.br_type = BrGe;
          3'd6: ctrl.br_type = BrLtu;
          3'd7: ctrl.br_type = BrGeu;
          default: illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        wr = 1'b1; ctrl.mem_ren = 1'b1; ctrl.mem_size = f3; ctrl.src2_sel = Src2Imm;
        ctrl.imm = imm_i;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OpStore: begin
        ctrl.mem_wen = 1'b1; ctrl.mem_size = f3; ctrl.src2_sel = Src2Imm; ctrl.imm = imm_s;
        illegal = (f3 > 3'd2);
      end
      OpImm: begin
        wr = 1'b1; ctrl.src2_sel = Src2Imm; ctrl.imm = imm_i;
        case (f3)
          3'd0: ctrl.alu_op = AluAdd;
          3'd1: begin ctrl.alu_op = AluSll; illegal = (f7 != 7'h00); end
          3'd2: ctrl.alu_op = AluSlt;
          3'd3: ctrl.alu_op = AluSltu;
          3'd4: ctrl.alu_op = AluXor;
          3'd5: begin
            ctrl.alu_op = f7[5] ? AluSra : AluSrl;
            illegal     = (f7 != 7'h00) && (f7 != 7'h20);
          end
          3'd6: ctrl.alu_op = AluOr;
          default: ctrl.alu_op = AluAnd;
        endcase
      end
      OpReg: begin
        wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: ctrl.alu_op = AluAdd;
          {7'h20, 3'd0}: ctrl.alu_op = AluSub;
          {7'h00, 3'd1}: ctrl.alu_op = AluSll;
          {7'h00, 3'd2}: ctrl.alu_op = AluSlt;
          {7'h00, 3'd3}: ctrl.alu_op = AluSltu;
          {7'h00, 3'd4}: ctrl.alu_op = AluXor;
          {7'h00, 3'd5}: ctrl.alu_op = AluSrl;
          {7'h20, 3'd5}: ctrl.alu_op = AluSra;
          {7'h00, 3'd6}: ctrl.alu_op = AluOr;
          {7'h00, 3'd7}: ctrl.alu_op = AluAnd;
          default:       illegal = 1'b1;
        endcase
      end
      OpMiscMem: ;
      OpSystem: begin
        if (inst_q == EcallInst) ctrl.ecall = 1'b1;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl = '0;
      wr   = 1'b0;
    end
    ctrl.illegal = illegal;
    ctrl.rd_wen  = wr && (rd_idx != 5'd0);
    ctrl.rd      = ctrl.rd_wen ? rd_idx : 5'd0;
    ctrl.rs1_val = rs1_val;
    ctrl.rs2_val = rs2_val;
    ctrl.pc      = pc_q;
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected decode results are queued at issue and checked when
// the stage hands an instruction to execute.
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;
    logic        ecall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_flush;
  logic        ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic [31:0] ws_rf_wdata;
  logic        ds_stall_flag, ecall_flag;
  es_fwd_t     es_fwd;
  ms_fwd_t     ms_fwd;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  id_stage_if pipe ();

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pipe          (pipe),
    .ds_stall_flag (ds_stall_flag),
    .ecall_flag    (ecall_flag),
    .exe_flush     (exe_flush),
    .es_fwd_bus    (es_fwd),
    .ms_fwd_bus    (ms_fwd),
    .ws_rf_we      (ws_rf_we),
    .ws_rf_waddr   (ws_rf_waddr),
    .ws_rf_wdata   (ws_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, imm, rs1, rs2, input logic [4:0] rd,
                              input logic rd_wen, illegal, ecall);
    exp_t e;
    e = '{pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd, rd_wen: rd_wen, illegal: illegal,
          ecall: ecall};
    return e;
  endfunction

  // Offer one instruction to decode; returns just after the accepting edge.
  task automatic issue(input logic [31:0] inst, pc, input logic keep, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!pipe.ds_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("allowin_wait", pipe.ds_allowin, 1);
    pipe.fs_to_ds_valid = 1'b1;
    pipe.if_id_bus      = {inst, pc};
    if (keep) sb.push_back(e);
    @(posedge clk);
    #1;
    pipe.fs_to_ds_valid = 1'b0;
  endtask

  task automatic ws_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    ws_rf_we    = 1'b1;
    ws_rf_waddr = addr;
    ws_rf_wdata = data;
    @(posedge clk);
    #1;
    ws_rf_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && pipe.ds_to_es_valid && pipe.es_allowin) begin
      check_eq("sb_avail", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("pc",      pipe.id_exe_bus.pc,      mon_e.pc);
        check_eq("imm",     pipe.id_exe_bus.imm,     mon_e.imm);
        check_eq("rs1_val", pipe.id_exe_bus.rs1_val, mon_e.rs1);
        check_eq("rs2_val", pipe.id_exe_bus.rs2_val, mon_e.rs2);
        check_eq("rd",      pipe.id_exe_bus.rd,      mon_e.rd);
        check_eq("rd_wen",  pipe.id_exe_bus.rd_wen,  mon_e.rd_wen);
        check_eq("illegal", pipe.id_exe_bus.illegal, mon_e.illegal);
        check_eq("ecall",   pipe.id_exe_bus.ecall,   mon_e.ecall);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    exe_flush = 1'b0;
    ws_rf_we = 1'b0;
    ws_rf_waddr = '0;
    ws_rf_wdata = '0;
    es_fwd = '0;
    ms_fwd = '0;
    pipe.fs_to_ds_valid = 1'b0;
    pipe.if_id_bus = '0;
    pipe.es_allowin = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_allowin", pipe.ds_allowin, 1);
    check_eq("rst_valid",   pipe.ds_to_es_valid, 0);
    check_eq("rst_stall",   ds_stall_flag, 0);
    check_eq("rst_ecall",   ecall_flag, 0);

    ws_write(5'd1, 32'h0000_0100);
    ws_write(5'd2, 32'h0000_0200);

    // ADDI x1,x0,5 -> one-cycle latency
    issue(32'h0050_0093, 32'h0, 1'b1, mk(32'h0, 32'd5, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check_eq("lat1", pipe.ds_to_es_valid, 1);

    // ADD x8,x7,x0 while x7 is being written back
    issue(32'h0003_8433, 32'h4, 1'b1, mk(32'h4, 32'h0, 32'h1234, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0));
    ws_rf_we = 1'b1; ws_rf_waddr = 5'd7; ws_rf_wdata = 32'h1234;
    @(negedge clk);
    @(posedge clk);
    #1 ws_rf_we = 1'b0;

    // ADD x9,x5,x0: EXE forward beats MEM forward
    es_fwd = '{valid: 1'b1, is_load: 1'b0, rd: 5'd5, value: 32'hDEAD};
    ms_fwd = '{valid: 1'b1, rd: 5'd5, value: 32'hBEEF};
    issue(32'h0002_84B3, 32'h8, 1'b1, mk(32'h8, 32'h0, 32'hDEAD, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    @(posedge clk);
    #1;

    // ADD x10,x1,x2: MEM forward on rs2, register file on rs1
    es_fwd = '{valid: 1'b1, is_load: 1'b0, rd: 5'd3, value: 32'h5555};
    ms_fwd = '{valid: 1'b1, rd: 5'd2, value: 32'hBEEF};
    issue(32'h0020_8533, 32'hC, 1'b1,
          mk(32'hC, 32'h0, 32'h100, 32'hBEEF, 5'd10, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    @(posedge clk);
    #1 es_fwd = '0;
    ms_fwd = '0;

    // Load-use: LW x2 in EXE, decode ADD x3,x2,x2
    es_fwd = '{valid: 1'b1, is_load: 1'b1, rd: 5'd2, value: 32'h0};
    issue(32'h0021_01B3, 32'h10, 1'b1,
          mk(32'h10, 32'h0, 32'hCAFE, 32'hCAFE, 5'd3, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check_eq("lu_stall",   ds_stall_flag, 1);
    check_eq("lu_allowin", pipe.ds_allowin, 0);
    check_eq("lu_valid",   pipe.ds_to_es_valid, 0);
    @(posedge clk);
    #1 es_fwd = '0;
    ms_fwd = '{valid: 1'b1, rd: 5'd2, value: 32'hCAFE};
    @(negedge clk);
    check_eq("lu_clear", ds_stall_flag, 0);
    @(posedge clk);
    #1 ms_fwd = '0;

    // SW x2,-4(x1) held while execute is busy
    pipe.es_allowin = 1'b0;
    issue(32'hFE20_AE23, 32'h14, 1'b1,
          mk(32'h14, 32'hFFFF_FFFC, 32'h100, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_eq("hold_valid",   pipe.ds_to_es_valid, 1);
    check_eq("hold_allowin", pipe.ds_allowin, 0);
    @(negedge clk);
    check_eq("hold_allowin2", pipe.ds_allowin, 0);
    @(posedge clk);
    #1 pipe.es_allowin = 1'b1;
    @(negedge clk);

    // JAL x1,+8 and LUI x4,0x12345
    issue(32'h0080_00EF, 32'h18, 1'b1, mk(32'h18, 32'd8, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0));
    issue(32'h1234_5237, 32'h1C, 1'b1,
          mk(32'h1C, 32'h1234_5000, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0));

    // Flush with a new fetch pending: both are discarded
    issue(32'h0050_0093, 32'h20, 1'b0, mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    pipe.fs_to_ds_valid = 1'b1;
    pipe.if_id_bus = {32'h0050_0093, 32'h24};
    exe_flush = 1'b1;
    @(negedge clk);
    check_eq("flush_out", pipe.ds_to_es_valid, 0);
    @(posedge clk);
    #1 exe_flush = 1'b0;
    pipe.fs_to_ds_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_drop",    pipe.ds_to_es_valid, 0);
    check_eq("flush_allowin", pipe.ds_allowin, 1);

    // ECALL pulses for exactly one cycle
    issue(32'h0000_0073, 32'h30, 1'b1, mk(32'h30, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    check_eq("ecall_hi", ecall_flag, 1);
    @(negedge clk);
    check_eq("ecall_lo", ecall_flag, 0);

    // Opcode 7'h7F with rd=31 is illegal and writes nothing
    issue(32'h0000_0FFF, 32'h34, 1'b1, mk(32'h34, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0));

    repeat (3) @(negedge clk);
    check_eq("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
